soc_trace_event_capture: RTL and testbench
==========================================

// Module: soc_trace_event_capture
// PURPOSE
//  Per-core trace front end between a core's trace_exec port and the tile trace consumers (soc_trace_monitor, CTM).
//  - Keeps a shadow of register R3_INDEX.
//  - Decodes RISC-V simulation-control NOPs (addi x0,x0,K) into typed events.
//  - Buffers events in a FIFO with valid/ready output and sequences termination after exit.
// PARAMETERS
//  DEPTH     8  event FIFO entries; power of 2, >=2
//  R3_INDEX  3  architectural register shadowed as event payload
//  DROP_W    16 width of saturating dropped-event counter
// PORTS
//  clk           in   1   system clock
//  rst           in   1   asynchronous, active-low reset
//  trace_valid   in   1   retired instruction this cycle
//  trace_pc      in   32  pc of retired instruction
//  trace_insn    in   32  encoding of retired instruction
//  trace_wben    in   1   register write-back enable
//  trace_wbreg   in   5   write-back register index
//  trace_wbdata  in   32  write-back data
//  evt_valid     out  1   FIFO head valid
//  evt_ready     in   1   consumer accepts head
//  evt_type      out  2   0=EXIT(K=1) 1=REPORT(K=2) 2=PUTC(K=4) 3=unused
//  evt_pc        out  32  pc of the control NOP
//  evt_data      out  32  shadow r3 value when the NOP retired
//  evt_ts        out  32  cycle timestamp (only with SOC_TRACE_TIMESTAMP_EN)
//  r3            out  32  current shadow register value
//  dropped       out  DROP_W  events lost to full FIFO, saturating
//  terminated    out  1   sticky; exit seen and FIFO drained
// BEHAVIOUR
//  Reset values (rst=0, async): all outputs 0, FIFO empty, state RUN, shadow 0, timestamp 0.
//  Decode: magic = trace_valid & insn[19:0]==20'h00013; K = insn[31:20].
//  - Event pushed for K in {1,2,4}.
//  - Other K values, and ordinary addi x0,x0,0 (K=0), are ignored.
//  Shadow r3: updates on trace_valid & wben & wbreg==R3_INDEX, visible next cycle.
//  - Writes with wbreg==0 never touch the shadow.
//  - Events carry the registered (pre-update) shadow value.
//  Latency: control NOP on cycle N gives evt_valid=1 on N+1 if FIFO was empty. No combinational in->out path.
//  Handshake: pop on evt_valid & evt_ready.
//  - evt_* hold stable while evt_valid & !evt_ready.
//  FIFO full:
//  - Push in the same cycle as a pop is accepted; count unchanged.
//  - Push without pop is dropped; dropped += 1, saturating at all-ones.
//  Pointers: log2(DEPTH) bits plus a wrap bit; full/empty from pointer compare. Wrap at DEPTH is exercised.
//  FSM:
//  - RUN: capture events.
//  - RUN->DRAIN: on EXIT push accepted; if the EXIT was dropped, DRAIN is entered anyway.
//  - DRAIN: decode disabled (later trace ignored, shadow still updates); pops continue.
//  - DRAIN->DONE: when FIFO is empty.
//  - DONE: terminated=1, sticky until reset.
//  - Only in RUN does an EXIT cause a transition; EXIT in DRAIN/DONE is ignored.
//  Reset mid-operation: FIFO contents, dropped, state and terminated are all cleared immediately.
// CONFIGURATION
//  SOC_TRACE_TIMESTAMP_EN defined:
//  - 32-bit free-running cycle counter, wraps at 2^32.
//  - Its value at push is stored per entry and presented on evt_ts.
//  Not defined: no counter or per-entry storage; evt_ts port absent.
// TESTING
//  1. Reset: hold rst=0 with random trace -> all outputs 0; release -> evt_valid stays 0 with no NOPs.
//  2. wb x3=0x1234 at cyc 5, insn 0x00400013 @pc 0x100 at cyc 6 -> cyc 7: evt_valid, type 2, pc 0x100, data 0x1234.
//  3. Hold evt_ready=0, issue 10 REPORT NOPs with DEPTH=8 -> 8 buffered, dropped=2. Pop all -> order and pc match issue order.
//  4. Full FIFO, ready=1, NOP same cycle -> accepted, dropped unchanged. Also run 20 push/pop cycles to cross pointer wrap.
//  5. EXIT (0x00100013) with 3 events ahead, ready=0 -> terminated=0, later PUTC ignored. Ready=1 -> 4 pops, then terminated=1.
//  6. Assert rst while in DRAIN with 2 entries -> evt_valid=0, terminated=0, RUN after release. [TS_EN] evt_ts delta equals cycle delta.

Source files
------------

// File: rtl/soc_trace_event_capture.sv
// Per-core trace front end: shadows one register, decodes simulation-control NOPs into events, and buffers them in a FIFO.
// Define SOC_TRACE_TIMESTAMP_EN to add a free-running cycle counter and the per-event evt_ts output.
module soc_trace_event_capture #(
    parameter int DEPTH    = 8,
    parameter int R3_INDEX = 3,
    parameter int DROP_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trace_valid,
    input  logic [31:0]       trace_pc,
    input  logic [31:0]       trace_insn,
    input  logic              trace_wben,
    input  logic [4:0]        trace_wbreg,
    input  logic [31:0]       trace_wbdata,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [1:0]        evt_type,
    output logic [31:0]       evt_pc,
    output logic [31:0]       evt_data,
`ifdef SOC_TRACE_TIMESTAMP_EN
    output logic [31:0]       evt_ts,
`endif
    output logic [31:0]       r3,
    output logic [DROP_W-1:0] dropped,
    output logic              terminated,
    output logic [1:0]        dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [4:0] R3_SEL = 5'(R3_INDEX);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW:0]       wr_ptr, rd_ptr;
    logic [AW-1:0]     wr_idx, rd_idx;
    logic [1:0]        type_mem [DEPTH];
    logic [31:0]       pc_mem   [DEPTH];
    logic [31:0]       data_mem [DEPTH];
    logic [31:0]       shadow_q;
    logic [DROP_W-1:0] dropped_q;
    logic [11:0]       k;
    logic [1:0]        k_type;
    logic              magic, evt_hit, is_exit;
    logic              fifo_empty, fifo_full, push, pop, drop;

    // Decode is gated by RUN so that trace after an exit never reaches the FIFO.
    always_comb begin
        k       = trace_insn[31:20];
        magic   = trace_valid && (trace_insn[19:0] == 20'h00013);
        evt_hit = 1'b0;
        k_type  = 2'd0;
        case (k)
            12'd1: begin evt_hit = magic; k_type = 2'd0; end
            12'd2: begin evt_hit = magic; k_type = 2'd1; end
            12'd4: begin evt_hit = magic; k_type = 2'd2; end
            default: begin evt_hit = 1'b0; k_type = 2'd0; end
        endcase
        evt_hit = evt_hit && (state_q == ST_RUN);
        is_exit = evt_hit && (k == 12'd1);
    end

    // Extra pointer bit distinguishes full from empty when indices are equal.
    assign wr_idx     = wr_ptr[AW-1:0];
    assign rd_idx     = rd_ptr[AW-1:0];
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign pop        = !fifo_empty && evt_ready;
    assign push       = evt_hit && (!fifo_full || pop);
    assign drop       = evt_hit && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Payload storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            type_mem[wr_idx] <= k_type;
            pc_mem[wr_idx]   <= trace_pc;
            data_mem[wr_idx] <= shadow_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q <= '0;
        end else if (trace_valid && trace_wben && (trace_wbreg == R3_SEL) && (trace_wbreg != 5'd0)) begin
            shadow_q <= trace_wbdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dropped_q <= '0;
        end else if (drop && (dropped_q != {DROP_W{1'b1}})) begin
            dropped_q <= dropped_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_RUN;
        else      state_q <= state_d;
    end

    // An exit moves to DRAIN whether or not its FIFO push succeeded.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (is_exit) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RUN;
        endcase
    end

`ifdef SOC_TRACE_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] ts_mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ts_cnt <= '0;
        else      ts_cnt <= ts_cnt + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (push) ts_mem[wr_idx] <= ts_cnt;
    end

    assign evt_ts = fifo_empty ? 32'd0 : ts_mem[rd_idx];
`endif

    assign evt_valid  = !fifo_empty;
    assign evt_type   = fifo_empty ? 2'd0  : type_mem[rd_idx];
    assign evt_pc     = fifo_empty ? 32'd0 : pc_mem[rd_idx];
    assign evt_data   = fifo_empty ? 32'd0 : data_mem[rd_idx];
    assign r3         = shadow_q;
    assign dropped    = dropped_q;
    assign terminated = (state_q == ST_DONE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_soc_trace_event_capture.sv
// Directed bench for soc_trace_event_capture: driver tasks push expected events, a negedge monitor checks every pop.
// Handshake: an event transfers on a rising edge where evt_valid and evt_ready are both high.
module tb_soc_trace_event_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trace_valid = 1'b0;
    logic [31:0] trace_pc = '0;
    logic [31:0] trace_insn = '0;
    logic        trace_wben = 1'b0;
    logic [4:0]  trace_wbreg = '0;
    logic [31:0] trace_wbdata = '0;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [1:0]  evt_type;
    logic [31:0] evt_pc;
    logic [31:0] evt_data;
    logic [31:0] r3;
    logic [15:0] dropped;
    logic        terminated;
    logic [1:0]  dbg_state;
`ifdef SOC_TRACE_TIMESTAMP_EN
    logic [31:0] evt_ts;
    logic [31:0] ts_log[$];
`endif

    int          checks = 0;
    int          errors = 0;
    logic [65:0] exp_q[$];
    logic [31:0] sh_r3 = '0;

    soc_trace_event_capture #(.DEPTH(8), .R3_INDEX(3), .DROP_W(16)) dut (
        .clk(clk), .rst(rst),
        .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_insn(trace_insn),
        .trace_wben(trace_wben), .trace_wbreg(trace_wbreg), .trace_wbdata(trace_wbdata),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type),
        .evt_pc(evt_pc), .evt_data(evt_data),
`ifdef SOC_TRACE_TIMESTAMP_EN
        .evt_ts(evt_ts),
`endif
        .r3(r3), .dropped(dropped), .terminated(terminated), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got type %0d pc %h data %h, expected none",
                         evt_type, evt_pc, evt_data);
            end else begin
                check("event", {evt_type, evt_pc, evt_data}, exp_q.pop_front());
            end
`ifdef SOC_TRACE_TIMESTAMP_EN
            ts_log.push_back(evt_ts);
`endif
        end
    end

    // driver tasks
    task automatic push_exp(input logic [1:0] t, input logic [31:0] pc);
        exp_q.push_back({t, pc, sh_r3});
    endtask

    task automatic drive_nop(input logic [11:0] k, input logic [31:0] pc);
        trace_valid = 1'b1;
        trace_pc    = pc;
        trace_insn  = {k, 20'h00013};
        trace_wben  = 1'b0;
        trace_wbreg = 5'd0;
        @(posedge clk); #1;
        trace_valid = 1'b0;
        trace_insn  = '0;
    endtask

    task automatic drive_wb(input logic [4:0] rd, input logic [31:0] data);
        trace_valid  = 1'b1;
        trace_pc     = 32'h0000_0f00;
        trace_insn   = 32'h002081b3;
        trace_wben   = 1'b1;
        trace_wbreg  = rd;
        trace_wbdata = data;
        @(posedge clk); #1;
        trace_valid = 1'b0;
        trace_wben  = 1'b0;
        if (rd == 5'd3) sh_r3 = data;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        evt_ready = 1'b1;
        while (evt_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drained"}, evt_valid, 1'b0);
        check({name, "_queue_left"}, exp_q.size(), 0);
        evt_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rnd;
        int          n;

        // 1: reset with random trace, then idle non-NOP trace
        repeat (5) begin
            trace_valid  = 1'($urandom_range(0, 1));
            trace_insn   = $urandom();
            trace_pc     = $urandom();
            trace_wben   = 1'($urandom_range(0, 1));
            trace_wbreg  = 5'($urandom_range(0, 31));
            trace_wbdata = $urandom();
            evt_ready    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        check("rst_evt_valid", evt_valid, 1'b0);
        check("rst_evt_fields", {evt_type, evt_pc, evt_data}, '0);
        check("rst_r3", r3, 32'd0);
        check("rst_dropped", dropped, 16'd0);
        check("rst_terminated", terminated, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        trace_valid = 1'b0;
        trace_wben  = 1'b0;
        evt_ready   = 1'b0;
        rst = 1'b1;
        repeat (5) begin
            rnd = $urandom();
            rnd[6:0] = 7'h33;
            trace_valid = 1'b1;
            trace_insn  = rnd;
            trace_pc    = $urandom();
            @(posedge clk); #1;
        end
        trace_valid = 1'b0;
        check("idle_evt_valid", evt_valid, 1'b0);
        check("idle_r3", r3, 32'd0);

        // 2: ignored K values, shadow write, PUTC latency
        drive_nop(12'd0, 32'h0000_0080);
        drive_nop(12'd3, 32'h0000_0084);
        drive_nop(12'd8, 32'h0000_0088);
        check("ignored_k", evt_valid, 1'b0);
        drive_wb(5'd0, 32'hdead_beef);
        check("wb_x0_no_effect", r3, 32'd0);
        drive_wb(5'd3, 32'h0000_1234);
        check("shadow_r3", r3, 32'h0000_1234);
        push_exp(2'd2, 32'h0000_0100);
        drive_nop(12'd4, 32'h0000_0100);
        check("latency_valid", evt_valid, 1'b1);
        wait_drain("putc");

        // 3: overflow with ready low
        for (int i = 0; i < 10; i++) begin
            if (i < 8) push_exp(2'd1, 32'h200 + 32'(4 * i));
            drive_nop(12'd2, 32'h200 + 32'(4 * i));
        end
        check("overflow_dropped", dropped, 16'd2);
        wait_drain("overflow");

        // 4: push while full with pop, then streaming across pointer wrap
        for (int i = 0; i < 8; i++) begin
            push_exp(2'd1, 32'h300 + 32'(4 * i));
            drive_nop(12'd2, 32'h300 + 32'(4 * i));
        end
        evt_ready = 1'b1;
        push_exp(2'd2, 32'h0000_0320);
        drive_nop(12'd4, 32'h0000_0320);
        evt_ready = 1'b0;
        check("full_push_pop_dropped", dropped, 16'd2);
        check("full_push_pop_valid", evt_valid, 1'b1);
        evt_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i % 5 == 4) begin
                drive_wb(5'd3, 32'h0000_a000 + 32'(i));
            end else begin
                push_exp(2'd2, 32'h400 + 32'(4 * i));
                drive_nop(12'd4, 32'h400 + 32'(4 * i));
            end
        end
        wait_drain("stream");

        // 5: exit with events ahead, drain, terminate
        for (int i = 0; i < 3; i++) begin
            push_exp(2'd2, 32'h500 + 32'(4 * i));
            drive_nop(12'd4, 32'h500 + 32'(4 * i));
        end
        push_exp(2'd0, 32'h0000_0510);
        drive_nop(12'd1, 32'h0000_0510);
        check("exit_not_terminated", terminated, 1'b0);
        check("exit_state_drain", dbg_state, 2'd1);
        drive_nop(12'd4, 32'h0000_0520);
        drive_nop(12'd1, 32'h0000_0524);
        drive_wb(5'd3, 32'h0000_abcd);
        check("drain_shadow_update", r3, 32'h0000_abcd);
        check("drain_still_drain", dbg_state, 2'd1);
        wait_drain("exit");
        n = 0;
        while (!terminated && n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        check("terminated", terminated, 1'b1);
        drive_nop(12'd4, 32'h0000_0530);
        idle(1);
        check("done_ignores_nop", evt_valid, 1'b0);
        check("done_sticky", terminated, 1'b1);

        // 6: reset while draining
        rst = 1'b0;
        #2;
        check("rst2_terminated", terminated, 1'b0);
        rst = 1'b1;
        sh_r3 = '0;
        exp_q.delete();
        @(posedge clk); #1;
        push_exp(2'd2, 32'h0000_0600);
        drive_nop(12'd4, 32'h0000_0600);
        push_exp(2'd0, 32'h0000_0604);
        drive_nop(12'd1, 32'h0000_0604);
        drive_nop(12'd2, 32'h0000_0608);
        drive_nop(12'd2, 32'h0000_060c);
        drive_nop(12'd2, 32'h0000_0610);
        drive_nop(12'd2, 32'h0000_0614);
        drive_nop(12'd2, 32'h0000_0618);
        drive_nop(12'd2, 32'h0000_061c);
        drive_nop(12'd2, 32'h0000_0620);
        check("pre_rst_state_drain", dbg_state, 2'd1);
        check("pre_rst_valid", evt_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", evt_valid, 1'b0);
        check("mid_rst_terminated", terminated, 1'b0);
        check("mid_rst_dropped", dropped, 16'd0);
        check("mid_rst_state", dbg_state, 2'd0);
        exp_q.delete();
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        push_exp(2'd2, 32'h0000_0700);
        drive_nop(12'd4, 32'h0000_0700);
        check("post_rst_valid", evt_valid, 1'b1);
        check("post_rst_state_run", dbg_state, 2'd0);
        wait_drain("post_rst");

`ifdef SOC_TRACE_TIMESTAMP_EN
        ts_log.delete();
        push_exp(2'd1, 32'h0000_0800);
        drive_nop(12'd2, 32'h0000_0800);
        idle(2);
        push_exp(2'd1, 32'h0000_0804);
        drive_nop(12'd2, 32'h0000_0804);
        wait_drain("ts");
        check("ts_count", ts_log.size(), 2);
        if (ts_log.size() == 2) check("ts_delta", ts_log[1] - ts_log[0], 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
